// File: rtl/rename_regfile_ckpt.sv
// rtl/rename_regfile_ckpt.sv - architectural register file with rename table and checkpoint ring
module rename_regfile_ckpt #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAGW  = 4,
  parameter int NRP   = 2,
  parameter int NCKPT = 4,
  localparam int RW   = $clog2(NREG),
  localparam int CKW  = $clog2(NCKPT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [NRP*RW-1:0]     rd_idx,
  output logic [NRP-1:0]        rd_busy,
  output logic [NRP*TAGW-1:0]   rd_tag,
  output logic [NRP*XLEN-1:0]   rd_val,
  input  logic                  ren_en,
  input  logic [RW-1:0]         ren_reg,
  input  logic [TAGW-1:0]       ren_tag,
  input  logic                  cmt_en,
  input  logic [RW-1:0]         cmt_reg,
  input  logic [TAGW-1:0]       cmt_tag,
  input  logic [XLEN-1:0]       cmt_val,
  input  logic                  ckpt_save,
  output logic [CKW-1:0]        ckpt_id,
  output logic                  ckpt_full,
  output logic                  ckpt_empty,
  input  logic                  ckpt_free,
  input  logic                  ckpt_restore,
  input  logic [CKW-1:0]        ckpt_restore_id,
  input  logic                  flush
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy, n_busy;
  logic [TAGW-1:0] alias_tab [NREG];
  logic [TAGW-1:0] n_alias [NREG];
  logic [NREG-1:0] snap_busy [NCKPT];
  logic [NREG-1:0] n_snap_busy [NCKPT];
  logic [TAGW-1:0] snap_alias [NCKPT][NREG];
  logic [TAGW-1:0] n_snap_alias [NCKPT][NREG];
  logic [CKW-1:0]  head, tail, n_head, n_tail, rs_off, rs_head;
  logic [CKW:0]    count, n_count;
  logic [NCKPT-1:0] snap_vld;
  logic cmt_ok, ren_ok, full, empty, free_ok, save_ok, rs_ok;

  assign cmt_ok     = cmt_en && (cmt_reg != '0);
  assign ren_ok     = ren_en && (ren_reg != '0);
  assign full       = (count == (CKW+1)'(NCKPT));
  assign empty      = (count == '0);
  assign free_ok    = ckpt_free && !empty;
  // A full ring still accepts a save when the oldest slot is freed in the same cycle.
  assign save_ok    = ckpt_save && (!full || free_ok);
  assign rs_off     = ckpt_restore_id - head;
  assign rs_ok      = ckpt_restore && ({1'b0, rs_off} < count);
  assign rs_head    = (free_ok && (head != ckpt_restore_id)) ? head + CKW'(1) : head;
  assign ckpt_id    = tail;
  assign ckpt_full  = full;
  assign ckpt_empty = empty;

  genvar p;
  for (p = 0; p < NRP; p++) begin : g_rd
    logic [RW-1:0] idx;
    logic          byp, bsy;
    assign idx = rd_idx[p*RW +: RW];
    assign byp = cmt_en && (cmt_reg == idx) && busy[idx] && (alias_tab[idx] == cmt_tag);
    assign bsy = (idx != '0) && !byp && busy[idx];
    assign rd_busy[p]              = bsy;
    assign rd_tag[p*TAGW +: TAGW]  = bsy ? alias_tab[idx] : '0;
    assign rd_val[p*XLEN +: XLEN]  = (idx == '0) ? '0 : (byp ? cmt_val : regs[idx]);
  end

  always_comb begin
    for (int s = 0; s < NCKPT; s++)
      snap_vld[s] = ({1'b0, CKW'(s) - head} < count);
  end

  always_comb begin
    n_busy       = busy;
    n_alias      = alias_tab;
    n_snap_busy  = snap_busy;
    n_snap_alias = snap_alias;
    n_head       = head;
    n_tail       = tail;
    n_count      = count;
    // Live snapshots must not keep waiting on a tag that just committed.
    for (int s = 0; s < NCKPT; s++)
      if (cmt_ok && snap_vld[s] && (snap_alias[s][cmt_reg] == cmt_tag))
        n_snap_busy[s][cmt_reg] = 1'b0;
    if (flush) begin
      n_busy  = '0;
      n_head  = '0;
      n_tail  = '0;
      n_count = '0;
    end else if (rs_ok) begin
      n_busy  = snap_busy[ckpt_restore_id];
      n_alias = snap_alias[ckpt_restore_id];
      if (cmt_ok && (snap_alias[ckpt_restore_id][cmt_reg] == cmt_tag))
        n_busy[cmt_reg] = 1'b0;
      n_head  = rs_head;
      n_tail  = ckpt_restore_id;
      n_count = {1'b0, ckpt_restore_id - rs_head};
    end else begin
      if (cmt_ok && (alias_tab[cmt_reg] == cmt_tag) && !(ren_ok && (ren_reg == cmt_reg)))
        n_busy[cmt_reg] = 1'b0;
      if (ren_ok) begin
        n_busy[ren_reg]  = 1'b1;
        n_alias[ren_reg] = ren_tag;
      end
      if (save_ok) begin
        n_snap_busy[tail]  = n_busy;
        n_snap_alias[tail] = n_alias;
        n_tail             = tail + CKW'(1);
      end
      if (free_ok)
        n_head = head + CKW'(1);
      n_count = count + (CKW+1)'(save_ok) - (CKW+1)'(free_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r]      <= '0;
        alias_tab[r] <= '0;
      end
      for (int s = 0; s < NCKPT; s++) begin
        snap_busy[s] <= '0;
        for (int r = 0; r < NREG; r++)
          snap_alias[s][r] <= '0;
      end
      busy  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (cmt_ok)
        regs[cmt_reg] <= cmt_val;
      busy       <= n_busy;
      alias_tab  <= n_alias;
      snap_busy  <= n_snap_busy;
      snap_alias <= n_snap_alias;
      head       <= n_head;
      tail       <= n_tail;
      count      <= n_count;
    end
  end

endmodule
